// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_pkg
//  Description : Shared operation codes, FSM state type and small decode
//                helpers for the multi-cycle multiply/divide unit.
//  Contents    : OP_* operation encodings (6..7 are illegal)
//                state_t  IDLE / RUN / FIX
//                is_md_op, is_div_op, is_signed_op decode helpers
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Operations that go through the iterative engine.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Unsigned WIDTH-iteration engine. In multiply mode it runs a
//                shift-add over a 2*WIDTH accumulator; in divide mode it runs
//                a restoring shift-subtract leaving the quotient in the low
//                half and the remainder in the high half.
//  Ports       : clk     rising-edge clock
//                rst     asynchronous active-low reset
//                i_load  capture operands, clear counter, latch mode
//                i_step  perform one iteration
//                i_div   mode at load: 1 = divide, 0 = multiply
//                i_a     multiplicand / dividend magnitude
//                i_b     multiplier / divisor magnitude
//                o_acc   accumulator (product, or {remainder, quotient})
//                o_last  counter is on the final iteration
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_div,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_acc,
  output logic                 o_last
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_div;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;

  // Multiply: the carry out of the upper-half add is shifted back in so the
  // running product never loses its top bit.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: trial-subtract the divisor from the partial remainder shifted
  // left by one (WIDTH+1 bits so the shifted-out MSB is kept). A borrow means
  // restore, i.e. just take the shift with a 0 quotient bit.
  assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign o_acc  = r_acc;
  assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_opnd <= '0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_div  <= i_div;
      r_opnd <= i_div ? i_b : i_a;
      r_acc  <= {{WIDTH{1'b0}}, (i_div ? i_a : i_b)};
    end else if (i_step) begin
      r_acc  <= r_div ? w_div_next : w_mul_next;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle signed/unsigned multiply and divide with
//                architectural HI/LO registers and direct MTHI/MTLO writes.
//                Operands are converted to magnitudes at launch, iterated
//                unsigned in muldiv_iter, then sign-corrected in FIX.
//  Ports       : clk       rising-edge clock
//                rst       asynchronous active-low reset
//                start     launch op (accepted only when idle)
//                op        operation code (OP_* in muldiv_unit_pkg)
//                a, b      rs / rt operands
//                cancel    abort in-flight op; HI/LO untouched
//                busy      operation in flight
//                done      one-cycle pulse, HI/LO updated this cycle
//                div_zero  with done: last op was a divide by zero
//                hi, lo    HI and LO registers
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div_zero;

  // Per-operation context captured at launch.
  logic             r_neg_res;   // product / quotient must be negated
  logic             r_neg_rem;   // remainder takes the dividend's sign
  logic             r_div;
  logic             r_b_zero;
  logic [WIDTH-1:0] r_a_raw;     // original dividend for the divide-by-zero result

  logic             w_idle;
  logic             w_accept;
  logic             w_launch;
  logic             w_step;
  logic             w_write;
  logic             w_load;
  logic             w_last;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_hi_new;
  logic [WIDTH-1:0] w_lo_new;

  assign w_idle   = (r_state == S_IDLE);
  // cancel in IDLE has no effect of its own but still drops a same-cycle start.
  assign w_accept = w_idle && start && !cancel &&
                    (is_md_op(op) || (op == OP_MTHI) || (op == OP_MTLO));
  assign w_launch = w_accept && is_md_op(op);
  assign w_step   = (r_state == S_RUN) && !cancel;
  assign w_write  = (r_state == S_FIX) && !cancel;

  assign w_a_neg  = is_signed_op(op) && a[WIDTH-1];
  assign w_b_neg  = is_signed_op(op) && b[WIDTH-1];
  // Negating the most-negative value yields the same bit pattern, which is
  // exactly its unsigned magnitude, so no special case is needed.
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_div  (is_div_op(op)),
    .i_a    (w_a_mag),
    .i_b    (w_b_mag),
    .o_acc  (w_acc),
    .o_last (w_last)
  );

  // Sign correction. Signed overflow (most-negative / -1) falls out naturally:
  // the magnitude quotient is 2^(WIDTH-1), and negating it leaves it unchanged.
  assign w_prod = r_neg_res ? -w_acc : w_acc;
  assign w_quo  = r_neg_res ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_hi_new = w_prod[2*WIDTH-1:WIDTH];
    w_lo_new = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_b_zero) begin
        w_hi_new = r_a_raw;
        w_lo_new = '1;
      end else begin
        w_hi_new = w_rem;
        w_lo_new = w_quo;
      end
    end
  end

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end
      end
      S_RUN: begin
        if (cancel) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------- HI/LO and handshake ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= w_write;
      if (w_write) begin
        r_hi       <= w_hi_new;
        r_lo       <= w_lo_new;
        r_div_zero <= r_div && r_b_zero;
      end else if (w_accept) begin
        r_div_zero <= 1'b0;
        if (op == OP_MTHI) begin
          r_hi <= a;
        end
        if (op == OP_MTLO) begin
          r_lo <= a;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div     <= 1'b0;
      r_b_zero  <= 1'b0;
      r_a_raw   <= '0;
    end else if (w_launch) begin
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_div     <= is_div_op(op);
      r_b_zero  <= (b == '0);
      r_a_raw   <= a;
    end
  end

  assign busy     = !w_idle;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit at WIDTH=32 and
//                WIDTH=16. Expected results come from a behavioural
//                arithmetic model and travel through a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DIVU  = 3'd3;
  localparam logic [2:0] MTHI  = 3'd4;
  localparam logic [2:0] MTLO  = 3'd5;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_start, s_cancel, busy32, done32, dz32;
  logic [2:0]  s_op;
  logic [31:0] s_a, s_b, hi32, lo32;

  logic        t_start, t_cancel, busy16, done16, dz16;
  logic [2:0]  t_op;
  logic [15:0] t_a, t_b, hi16, lo16;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q32[$];
  exp_t q16[$];
  logic [31:0] arch_hi, arch_lo;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
    .cancel(s_cancel), .busy(busy32), .done(done32), .div_zero(dz32),
    .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(t_start), .op(t_op), .a(t_a), .b(t_b),
    .cancel(t_cancel), .busy(busy16), .done(done16), .div_zero(dz16),
    .hi(hi16), .lo(lo16)
  );

  // Reference arithmetic at width w using 64-bit integers.
  function automatic exp_t model(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask, ua, ub, p, h, l;
    longint          sa, sb, q, r, most_neg;
    exp_t            e;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = ua[w-1] ? ($signed(ua) - $signed(64'd1 << w)) : $signed(ua);
    sb   = ub[w-1] ? ($signed(ub) - $signed(64'd1 << w)) : $signed(ub);
    most_neg = -($signed(64'd1 << (w - 1)));
    h = 64'd0; l = 64'd0; e.dz = 1'b0;
    case (op)
      MULT:  begin p = $unsigned(sa * sb); h = p >> w; l = p; end
      MULTU: begin p = ua * ub;            h = p >> w; l = p; end
      DIV, DIVU: begin
        if (ub == 64'd0) begin
          h = ua; l = mask; e.dz = 1'b1;
        end else if (op == DIV) begin
          if (sa == most_neg && sb == -64'sd1) begin
            l = 64'd1 << (w - 1); h = 64'd0;
          end else begin
            q = sa / sb; r = sa % sb;
            l = $unsigned(q); h = $unsigned(r);
          end
        end else begin
          l = ua / ub; h = ua % ub;
        end
      end
      default: ;
    endcase
    h = h & mask;
    l = l & mask;
    e.hi = h[31:0];
    e.lo = l[31:0];
    return e;
  endfunction

  // All drivers are entered and left at #1 after a rising edge.
  task automatic drive32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    s_op = op; s_a = a; s_b = b; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
  endtask

  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op <= DIVU) q32.push_back(model(32, op, a, b));
    drive32(op, a, b);
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op <= DIVU) q16.push_back(model(16, op, {16'd0, a}, {16'd0, b}));
    t_op = op; t_a = a; t_b = b; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
  endtask

  task automatic wait32(output int n);
    n = 0;
    while (!done32 && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic wait16(output int n);
    n = 0;
    while (!done16 && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset;
    n_tests++; if (hi32 !== 32'd0)  begin n_fail++; $display("FAIL reset_hi32: got %h want 0", hi32); end
    n_tests++; if (lo32 !== 32'd0)  begin n_fail++; $display("FAIL reset_lo32: got %h want 0", lo32); end
    n_tests++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy32: got %b want 0", busy32); end
    n_tests++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL reset_done32: got %b want 0", done32); end
    n_tests++; if (dz32 !== 1'b0)   begin n_fail++; $display("FAIL reset_dz32: got %b want 0", dz32); end
    n_tests++; if ({hi16, lo16, busy16, done16} !== 34'd0)
      begin n_fail++; $display("FAIL reset_16: got %h/%h/%b/%b want zeros", hi16, lo16, busy16, done16); end
    arch_hi = 32'd0; arch_lo = 32'd0;
  endtask

  task automatic test_mult;
    logic [2:0]  ops [5] = '{MULT, MULTU, MULT, MULT, MULTU};
    logic [31:0] as  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0001_2345};
    logic [31:0] bs  [5] = '{32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0006_789A};
    exp_t e;
    int   n;
    for (int i = 0; i < 5; i++) begin
      issue32(ops[i], as[i], bs[i]);
      if (i == 0) begin
        n_tests++; if (busy32 !== 1'b1) begin n_fail++; $display("FAIL mult_busy_rise: got %b want 1", busy32); end
      end
      wait32(n);
      e = q32.pop_front();
      n_tests++;
      if (!done32) begin
        n_fail++; $display("FAIL mult%0d_timeout: done=%b after %0d cycles want 1", i, done32, n);
      end else begin
        if (i == 0) begin
          n_tests++; if (n !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d want 33", n); end
          n_tests++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL mult_busy_fall: got %b want 0", busy32); end
        end
        if (hi32 !== e.hi || lo32 !== e.lo || dz32 !== e.dz) begin
          n_fail++; $display("FAIL mult%0d_result: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                             i, hi32, lo32, dz32, e.hi, e.lo, e.dz);
        end
        arch_hi = e.hi; arch_lo = e.lo;
      end
      @(posedge clk); #1;
      n_tests++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL mult%0d_done_pulse: got %b want 0", i, done32); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [7] = '{DIV, DIVU, DIV, DIV, DIVU, DIV, DIV};
    logic [31:0] as  [7] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF9, 32'hDEADBEEF, 32'd100, 32'h7FFFFFFF};
    logic [31:0] bs  [7] = '{32'd2,        32'd0, 32'hFFFFFFFF, 32'd0,        32'h0000_1234, 32'hFFFFFFF9, 32'h7FFFFFFF};
    exp_t e;
    int   n;
    for (int i = 0; i < 7; i++) begin
      issue32(ops[i], as[i], bs[i]);
      wait32(n);
      e = q32.pop_front();
      n_tests++;
      if (!done32) begin
        n_fail++; $display("FAIL div%0d_timeout: done=%b after %0d cycles want 1", i, done32, n);
      end else begin
        if (hi32 !== e.hi || lo32 !== e.lo || dz32 !== e.dz || n !== 33) begin
          n_fail++; $display("FAIL div%0d_result: got hi=%h lo=%h dz=%b lat=%0d want hi=%h lo=%h dz=%b lat=33",
                             i, hi32, lo32, dz32, n, e.hi, e.lo, e.dz);
        end
        arch_hi = e.hi; arch_lo = e.lo;
      end
    end
  endtask

  task automatic test_cancel;
    logic seen;
    // Cancel in RUN with an ignored start along the way.
    drive32(DIVU, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    s_op = MULT; s_a = 32'd3; s_b = 32'd3; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n_tests++; if (busy32 !== 1'b1) begin n_fail++; $display("FAIL start_while_busy: busy=%b want 1", busy32); end
    repeat (4) begin @(posedge clk); #1; end
    s_cancel = 1'b1;
    @(posedge clk); #1;
    s_cancel = 1'b0;
    n_tests++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL cancel_run_busy: got %b want 0", busy32); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done32) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cancel_run_done: got %b want 0", seen); end
    n_tests++; if (hi32 !== arch_hi || lo32 !== arch_lo)
      begin n_fail++; $display("FAIL cancel_run_hilo: got %h/%h want %h/%h", hi32, lo32, arch_hi, arch_lo); end

    // Cancel exactly in FIX.
    drive32(MULT, 32'd7, 32'd9);
    repeat (32) begin @(posedge clk); #1; end
    s_cancel = 1'b1;
    @(posedge clk); #1;
    s_cancel = 1'b0;
    seen = done32;
    repeat (5) begin @(posedge clk); #1; if (done32) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0 || busy32 !== 1'b0)
      begin n_fail++; $display("FAIL cancel_fix: done=%b busy=%b want 0/0", seen, busy32); end
    n_tests++; if (hi32 !== arch_hi || lo32 !== arch_lo)
      begin n_fail++; $display("FAIL cancel_fix_hilo: got %h/%h want %h/%h", hi32, lo32, arch_hi, arch_lo); end

    // MTHI while busy is dropped.
    drive32(MULTU, 32'd5, 32'd5);
    drive32(MTHI, 32'hDEADBEEF, 32'd0);
    s_cancel = 1'b1;
    @(posedge clk); #1;
    s_cancel = 1'b0;
    n_tests++; if (hi32 !== arch_hi) begin n_fail++; $display("FAIL mthi_busy: got %h want %h", hi32, arch_hi); end

    // cancel together with start in IDLE: start dropped.
    s_cancel = 1'b1;
    drive32(MTHI, 32'hCAFEF00D, 32'd0);
    s_cancel = 1'b0;
    n_tests++; if (hi32 !== arch_hi || busy32 !== 1'b0)
      begin n_fail++; $display("FAIL cancel_start_idle: hi=%h busy=%b want %h/0", hi32, busy32, arch_hi); end

    // MTLO in IDLE.
    drive32(MTLO, 32'h12345678, 32'd0);
    arch_lo = 32'h12345678;
    n_tests++; if (lo32 !== 32'h12345678 || done32 !== 1'b0 || hi32 !== arch_hi)
      begin n_fail++; $display("FAIL mtlo: got lo=%h done=%b hi=%h want 12345678/0/%h", lo32, done32, hi32, arch_hi); end

    // MTHI in IDLE.
    drive32(MTHI, 32'hA5A5_0F0F, 32'd0);
    arch_hi = 32'hA5A5_0F0F;
    n_tests++; if (hi32 !== arch_hi || lo32 !== arch_lo)
      begin n_fail++; $display("FAIL mthi: got %h/%h want %h/%h", hi32, lo32, arch_hi, arch_lo); end

    // Illegal op is ignored.
    drive32(3'd6, 32'h0000AAAA, 32'd1);
    n_tests++; if (busy32 !== 1'b0 || hi32 !== arch_hi || lo32 !== arch_lo)
      begin n_fail++; $display("FAIL illegal_op: busy=%b hi=%h lo=%h want 0/%h/%h", busy32, hi32, lo32, arch_hi, arch_lo); end
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    int          n;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 3) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 300)));
      issue32(op, a, b);
      wait32(n);
      e = q32.pop_front();
      n_tests++;
      if (!done32) begin
        n_fail++; $display("FAIL b2b%0d_timeout: done=%b after %0d cycles want 1", i, done32, n);
      end else if (hi32 !== e.hi || lo32 !== e.lo || dz32 !== e.dz) begin
        n_fail++; $display("FAIL b2b%0d op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                           i, op, a, b, hi32, lo32, dz32, e.hi, e.lo, e.dz);
      end
      arch_hi = e.hi; arch_lo = e.lo;
    end
  endtask

  task automatic test_reset_mid;
    drive32(MULT, 32'h0000_1234, 32'h0000_5678);
    repeat (19) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (hi32 !== 32'd0 || lo32 !== 32'd0 || busy32 !== 1'b0 || done32 !== 1'b0)
      begin n_fail++; $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b want 0/0/0/0", hi32, lo32, busy32, done32); end
    rst = 1'b1;
    arch_hi = 32'd0; arch_lo = 32'd0;
    @(posedge clk); #1;
    repeat (40) begin @(posedge clk); #1; end
    n_tests++; if (done32 !== 1'b0 || hi32 !== 32'd0)
      begin n_fail++; $display("FAIL reset_mid_lost: done=%b hi=%h want 0/0", done32, hi32); end
  endtask

  task automatic test_width16;
    logic [2:0]  ops [5] = '{MULT, MULTU, MULT, DIV, DIVU};
    logic [15:0] as  [5] = '{16'hFFFD, 16'hFFFF, 16'hFFFF, 16'hFFF9, 16'd7};
    logic [15:0] bs  [5] = '{16'd5,    16'hFFFF, 16'hFFFF, 16'd2,    16'd0};
    exp_t e;
    int   n;
    for (int i = 0; i < 5; i++) begin
      issue16(ops[i], as[i], bs[i]);
      wait16(n);
      e = q16.pop_front();
      n_tests++;
      if (!done16) begin
        n_fail++; $display("FAIL w16_%0d_timeout: done=%b after %0d cycles want 1", i, done16, n);
      end else if (hi16 !== e.hi[15:0] || lo16 !== e.lo[15:0] || dz16 !== e.dz || n !== 17 || busy16 !== 1'b0) begin
        n_fail++; $display("FAIL w16_%0d: got hi=%h lo=%h dz=%b lat=%0d busy=%b want hi=%h lo=%h dz=%b lat=17 busy=0",
                           i, hi16, lo16, dz16, n, busy16, e.hi[15:0], e.lo[15:0], e.dz);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    s_start = 1'b0; s_cancel = 1'b0; s_op = 3'd0; s_a = 32'd0; s_b = 32'd0;
    t_start = 1'b0; t_cancel = 1'b0; t_op = 3'd0; t_a = 16'd0; t_b = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    test_mult;
    test_div;
    test_cancel;
    test_back_to_back;
    test_width16;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
